// File: rtl/weighted_rank_pipe.sv
// Two-stage weighted rank: masked comparison weights plus a centre weight, summed
// into two registered partial sums and then a registered total, with double-buffered weights.
module weighted_rank_pipe #(
    parameter int N  = 7,
    parameter int WB = 3,
    parameter int RB = $clog2(N*(2**WB-1)+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-2:0]         in_cmp,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [RB-1:0]        out_rank,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_idx,
    input  logic [WB-1:0]        cfg_wdata,
    input  logic                 cfg_commit
);
    localparam int IW = $clog2(N);
    localparam int H  = (N-1)/2;

    // Entry N-1 of each weight bank holds the centre weight.
    logic [WB-1:0] shadow_w [N];
    logic [WB-1:0] active_w [N];

    logic [RB-1:0] term [N-1];
    logic [RB-1:0] sum_lo_next;
    logic [RB-1:0] sum_hi_next;
    logic [RB-1:0] sum_lo_reg;
    logic [RB-1:0] sum_hi_reg;
    logic [RB-1:0] rank_reg;
    logic          v1;
    logic          v2;
    logic          s1_en;
    logic          s2_en;

    assign s2_en     = !v2 || out_ready;
    assign s1_en     = !v1 || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = v2;
    assign out_rank  = rank_reg;

    // Commit copies the pre-write shadow, so a same-cycle write lands only in the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                shadow_w[i] <= WB'(1);
                active_w[i] <= WB'(1);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cfg_commit)
                    active_w[i] <= shadow_w[i];
                if (cfg_we && cfg_idx == IW'(i))
                    shadow_w[i] <= cfg_wdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N-1; gi++) begin : g_term
            assign term[gi] = in_cmp[gi] ? RB'(active_w[gi]) : '0;
        end
    endgenerate

    always_comb begin
        sum_lo_next = '0;
        sum_hi_next = RB'(active_w[N-1]);
        for (int i = 0; i < H; i++)
            sum_lo_next = sum_lo_next + term[i];
        for (int i = H; i < N-1; i++)
            sum_hi_next = sum_hi_next + term[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            sum_lo_reg <= '0;
            sum_hi_reg <= '0;
        end else if (s1_en) begin
            v1 <= in_valid;
            if (in_valid) begin
                sum_lo_reg <= sum_lo_next;
                sum_hi_reg <= sum_hi_next;
            end
        end
    end

    // The result only moves when a new sample advances, so it is stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            rank_reg <= '0;
        end else if (s2_en) begin
            v2 <= v1;
            if (v1)
                rank_reg <= sum_lo_reg + sum_hi_reg;
        end
    end
endmodule

// File: tb/tb_weighted_rank_pipe.sv
// Directed bench for weighted_rank_pipe: rank arithmetic, weight commit timing,
// backpressure ordering and mid-stream reset.
module tb_weighted_rank_pipe;
    localparam int N  = 7;
    localparam int WB = 3;
    localparam int RB = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-2:0]  in_cmp = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RB-1:0] out_rank;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_idx = '0;
    logic [WB-1:0] cfg_wdata = '0;
    logic          cfg_commit = 1'b0;

    int total = 0;
    int bad = 0;

    weighted_rank_pipe #(.N(N), .WB(WB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_cmp(in_cmp), .in_valid(in_valid), .in_ready(in_ready),
        .out_rank(out_rank), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge where the result is presented.
    task automatic run_one(input string tag, input logic [5:0] cmp, input int exp);
        in_cmp = cmp;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val({tag, "_lat"}, 32'(out_valid), 0);
        @(posedge clk); #1;
        check_val({tag, "_valid"}, 32'(out_valid), 1);
        check_val(tag, 32'(out_rank), exp);
        $display("txn %s cmp=%b rank=%0d exp=%0d", tag, cmp, out_rank, exp);
    endtask

    task automatic cfg_write(input int idx, input int val);
        cfg_idx = 3'(idx);
        cfg_wdata = WB'(val);
        cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_do_commit();
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
    endtask

    initial begin
        int exp_q [4] = '{1, 2, 3, 4};
        int sent, got, low_cnt;
        logic [RB-1:0] held;
        bit held_v;
        bit acc, fire;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_out_rank", 32'(out_rank), 0);
        check_val("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_in_ready", 32'(in_ready), 1);

        // Default weights give the unweighted rank.
        run_one("def_all", 6'b111111, 7);
        run_one("def_none", 6'b000000, 1);

        // Shadow writes are invisible until commit; index 7 is out of range.
        cfg_write(0, 3); cfg_write(1, 2);
        for (int i = 2; i < 6; i++) cfg_write(i, 0);
        cfg_write(6, 1);
        cfg_write(7, 7);
        run_one("shadow_only", 6'b000011, 3);
        cfg_do_commit();
        run_one("wt_low", 6'b000011, 6);
        run_one("wt_high", 6'b111100, 1);

        for (int i = 0; i < 7; i++) cfg_write(i, 7);
        cfg_do_commit();
        run_one("max_sum", 6'b111111, 49);
        run_one("max_centre", 6'b000000, 7);
        cfg_write(6, 0);
        cfg_do_commit();
        run_one("wc0_one", 6'b000001, 7);
        run_one("wc0_none", 6'b000000, 0);

        // Binary weights on the low bits so each stalled sample has a distinct result.
        cfg_write(0, 1); cfg_write(1, 2); cfg_write(2, 4);
        for (int i = 3; i < 7; i++) cfg_write(i, 0);
        cfg_do_commit();
        sent = 0; got = 0; low_cnt = 0; held_v = 0; held = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = (sent < 4);
            in_cmp = 6'(sent + 1);
            out_ready = (cyc >= 5);
            @(negedge clk);
            if (held_v) check_val("stall_hold", 32'(out_rank), 32'(held));
            if (!in_ready) low_cnt++;
            acc = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                if (got < 4) check_val($sformatf("stall_out%0d", got), 32'(out_rank), exp_q[got]);
                $display("txn stall_out%0d rank=%0d", got, out_rank);
                got++;
            end
            held_v = out_valid && !out_ready;
            held = out_rank;
            if (acc) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("stall_sent", sent, 4);
        check_val("stall_recv", got, 4);
        check_val("stall_inready_low", 32'(low_cnt > 0), 1);
        out_ready = 1'b1;

        // Mid-stream reset with a pending shadow write and two samples in flight.
        cfg_write(0, 6);
        in_cmp = 6'b000001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_cmp = 6'b000010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(out_valid), 0);
        check_val("mid_rst_rank", 32'(out_rank), 0);
        check_val("mid_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("rst_no_ghost", 32'(out_valid), 0);
        end
        run_one("rst_weights", 6'b000001, 2);
        cfg_do_commit();
        run_one("rst_shadow", 6'b000001, 2);

        // Commit on the same edge a sample is accepted: that sample keeps old weights.
        cfg_write(0, 5);
        in_cmp = 6'b000001; in_valid = 1'b1; cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        check_val("commit_edge_lat", 32'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("commit_old_valid", 32'(out_valid), 1);
        check_val("commit_old", 32'(out_rank), 2);
        $display("txn commit_old rank=%0d", out_rank);
        @(posedge clk); #1;
        check_val("commit_new_valid", 32'(out_valid), 1);
        check_val("commit_new", 32'(out_rank), 6);
        $display("txn commit_new rank=%0d", out_rank);

        // Write and commit together: commit takes the pre-write shadow value.
        cfg_idx = 3'd0; cfg_wdata = 3'd2; cfg_we = 1'b1; cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
        run_one("we_commit_old", 6'b000001, 6);
        cfg_do_commit();
        run_one("we_commit_new", 6'b000001, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
